scim_global_counter: RTL and testbench



---
 rtl/scim_gctr_pkg.sv | 35 +++
 rtl/scim_gctr_lane.sv | 46 ++++
 rtl/scim_global_counter.sv | 112 +++++++++++
 tb/tb_scim_global_counter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scim_gctr_pkg.sv
// Shared defaults, FSM encoding and saturating-add helper for the SCIM global counter.
// Widths up to 30 bits are covered by the 32-bit arithmetic in sat_add.
package scim_gctr_pkg;

  localparam int N_S_DEF    = 32;
  localparam int N_C_DEF    = 32;
  localparam int BCP_DEF    = 7;
  localparam int GCP_DEF    = 12;
  localparam int NACC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } gctr_state_e;

  // Adds two sign-extended operands and clamps the result to a w-bit two's complement range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] s;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    s  = a + b;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/scim_gctr_lane.sv
// One global-counter lane: saturating accumulator with sticky early-termination flag.
// A set trigger freezes the lane until the next clear or reset.
module scim_gctr_lane
  import scim_gctr_pkg::*;
#(
  parameter int BCP = BCP_DEF,
  parameter int GCP = GCP_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  clr_i,
  input  logic                  upd_i,
  input  logic                  et_en_i,
  input  logic [GCP-2:0]        et_thres_i,
  input  logic signed [BCP-1:0] bank_i,
  output logic signed [GCP-1:0] acc_o,
  output logic                  trig_o
);

  logic signed [GCP-1:0] acc_q;
  logic signed [GCP-1:0] acc_d;
  logic                  trig_q;
  logic                  trig_d;
  logic signed [GCP-1:0] neg_thr;
  logic                  hit;

  assign acc_d   = GCP'(sat_add(32'(acc_q), 32'(bank_i), GCP));
  assign neg_thr = -$signed({1'b0, et_thres_i});
  // Threshold is evaluated on the post-update sum so the trigger lands with that update.
  assign hit     = et_en_i && (acc_d <= neg_thr);
  assign trig_d  = trig_q || hit;

  always_ff @(posedge CLK) begin
    if (RESET || clr_i) begin
      acc_q  <= '0;
      trig_q <= 1'b0;
    end else if (upd_i && !trig_q) begin
      acc_q  <= acc_d;
      trig_q <= trig_d;
    end
  end

  assign acc_o  = acc_q;
  assign trig_o = trig_q;

endmodule

// File: rtl/scim_global_counter.sv
// SCIM global counter: accumulates bank-counter snapshots per lane over num_acc latch events,
// with per-lane early termination fed back to the bank and an early exit once all lanes stop.
module scim_global_counter
  import scim_gctr_pkg::*;
#(
  parameter int N_S    = N_S_DEF,
  parameter int N_C    = N_C_DEF,
  parameter int BCP    = BCP_DEF,
  parameter int GCP    = GCP_DEF,
  parameter int NACC_W = NACC_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [NACC_W-1:0]      num_acc,
  input  logic                   et_en,
  input  logic [GCP-2:0]         ET_THRES,
  input  logic                   acc_valid,
  input  logic [N_S*N_C*BCP-1:0] BANK_CTR_LATCHED,
  output logic [N_S*N_C-1:0]     ET_L1_TRIGG,
  output logic [N_S*N_C*GCP-1:0] GCTR_OUT,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   all_terminated
);

  localparam int L = N_S * N_C;

  gctr_state_e       state_q, state_d;
  logic [NACC_W-1:0] cnt_q, cnt_d;
  logic [NACC_W-1:0] num_q, num_d;
  logic              et_en_q, et_en_d;
  logic [GCP-2:0]    thres_q, thres_d;
  logic              all_term_q, all_term_d;
  logic              upd_w;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      et_en_q    <= 1'b0;
      thres_q    <= '0;
      all_term_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      et_en_q    <= et_en_d;
      thres_q    <= thres_d;
      all_term_q <= all_term_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    et_en_d = et_en_q;
    thres_d = thres_q;
    if (start) begin
      // Restart wins over everything, including a coincident snapshot.
      state_d = ST_ACCUM;
      cnt_d   = '0;
      num_d   = num_acc;
      et_en_d = et_en;
      thres_d = ET_THRES;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ACCUM: begin
          if (et_en_q && all_term_q) begin
            state_d = ST_DONE;
          end else if (acc_valid) begin
            cnt_d = cnt_q + 1'b1;
            // num_acc == 0 wraps to all-ones, giving 2^NACC_W events.
            if (cnt_q == num_q - 1'b1) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign all_term_d = (&ET_L1_TRIGG) && !start && (state_d != ST_IDLE);
  assign upd_w      = (state_q == ST_ACCUM) && acc_valid && !start;

  for (genvar i = 0; i < L; i++) begin : g_lane
    scim_gctr_lane #(
      .BCP(BCP),
      .GCP(GCP)
    ) u_lane (
      .CLK       (CLK),
      .RESET     (RESET),
      .clr_i     (start),
      .upd_i     (upd_w),
      .et_en_i   (et_en_q),
      .et_thres_i(thres_q),
      .bank_i    (BANK_CTR_LATCHED[i*BCP +: BCP]),
      .acc_o     (GCTR_OUT[i*GCP +: GCP]),
      .trig_o    (ET_L1_TRIGG[i])
    );
  end

  assign result_valid   = (state_q == ST_DONE) && !start;
  assign busy           = (state_q != ST_IDLE);
  assign all_terminated = all_term_q;

endmodule

// File: tb/tb_scim_global_counter.sv
// Scoreboard bench for scim_global_counter: a lane model predicts sums/triggers per snapshot.
module tb_scim_global_counter;

  localparam int N_S    = 32;
  localparam int N_C    = 32;
  localparam int BCP    = 7;
  localparam int GCP    = 12;
  localparam int NACC_W = 8;
  localparam int L      = N_S * N_C;
  localparam int SMAX   = 2 ** (GCP - 1) - 1;
  localparam int SMIN   = -(2 ** (GCP - 1));

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 start;
  logic [NACC_W-1:0]    num_acc;
  logic                 et_en;
  logic [GCP-2:0]       ET_THRES;
  logic                 acc_valid;
  logic [L*BCP-1:0]     BANK_CTR_LATCHED;
  logic [L-1:0]         ET_L1_TRIGG;
  logic [L*GCP-1:0]     GCTR_OUT;
  logic                 result_valid;
  logic                 busy;
  logic                 all_terminated;

  scim_global_counter #(
    .N_S(N_S), .N_C(N_C), .BCP(BCP), .GCP(GCP), .NACC_W(NACC_W)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .start           (start),
    .num_acc         (num_acc),
    .et_en           (et_en),
    .ET_THRES        (ET_THRES),
    .acc_valid       (acc_valid),
    .BANK_CTR_LATCHED(BANK_CTR_LATCHED),
    .ET_L1_TRIGG     (ET_L1_TRIGG),
    .GCTR_OUT        (GCTR_OUT),
    .result_valid    (result_valid),
    .busy            (busy),
    .all_terminated  (all_terminated)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    string tag;
    int    lane;
    int    sum;
    bit    trig;
  } exp_t;

  exp_t sb[$];
  int   m_acc[L];
  bit   m_trig[L];
  bit   m_et;
  int   m_thr;
  bit   m_active;
  int   snap[L];
  int   watch[4] = '{0, 1, 5, L - 1};

  function automatic int gsum(input int i);
    return int'($signed(GCTR_OUT[i*GCP +: GCP]));
  endfunction

  function automatic int n_bad();
    int n = 0;
    for (int i = 0; i < L; i++) begin
      if (gsum(i) != m_acc[i] || ET_L1_TRIGG[i] != m_trig[i]) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < L; i++) begin
      m_acc[i]  = 0;
      m_trig[i] = 1'b0;
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < L; i++) snap[i] = v;
  endtask

  task automatic drive_snap();
    for (int i = 0; i < L; i++) BANK_CTR_LATCHED[i*BCP +: BCP] = BCP'(snap[i]);
  endtask

  task automatic do_start(input int n, input bit en, input int thr);
    start    = 1'b1;
    num_acc  = NACC_W'(n);
    et_en    = en;
    ET_THRES = (GCP - 1)'(thr);
    model_clear();
    m_et     = en;
    m_thr    = thr;
    m_active = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rv", result_valid, 0);
    chk("start_lanes", n_bad(), 0);
  endtask

  // One snapshot: model predicts, watched lanes go to the scoreboard, popped after the DUT edge.
  task automatic ev(input string tag, input bit exp_rv);
    int s;
    drive_snap();
    acc_valid = 1'b1;
    if (m_active) begin
      for (int i = 0; i < L; i++) begin
        if (!m_trig[i]) begin
          s = m_acc[i] + snap[i];
          if (s > SMAX) s = SMAX;
          if (s < SMIN) s = SMIN;
          m_acc[i] = s;
          if (m_et && s <= -m_thr) m_trig[i] = 1'b1;
        end
      end
    end
    foreach (watch[k]) sb.push_back('{tag, watch[k], m_acc[watch[k]], m_trig[watch[k]]});
    tick();
    acc_valid = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("%s_l%0d_sum", e.tag, e.lane), gsum(e.lane), e.sum);
      chk($sformatf("%s_l%0d_trig", e.tag, e.lane), ET_L1_TRIGG[e.lane], e.trig);
    end
    chk({tag, "_rv"}, result_valid, exp_rv);
    if (exp_rv) begin
      chk({tag, "_lanes"}, n_bad(), 0);
      m_active = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    num_acc = '0;
    et_en = 1'b0;
    ET_THRES = '0;
    acc_valid = 1'b0;
    BANK_CTR_LATCHED = '0;
    m_active = 1'b0;
    m_et = 1'b0;
    m_thr = 0;
    model_clear();
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_allterm", all_terminated, 0);
    chk("rst_trig", |ET_L1_TRIGG, 0);
    chk("rst_lanes", n_bad(), 0);
    RESET = 1'b0;
    tick();

    // Basic: +3 x4 -> 12, result_valid right after the 4th edge
    do_start(4, 1'b0, 0);
    set_all(3);
    for (int k = 0; k < 4; k++) ev($sformatf("b%0d", k), k == 3);
    chk("b_sum0", gsum(0), 12);
    tick();
    chk("b_rv_drop", result_valid, 0);
    chk("b_idle", busy, 0);
    chk("b_hold", gsum(L - 1), 12);
    chk("b_trig", |ET_L1_TRIGG, 0);

    // Saturation over 256 events
    set_all(0);
    snap[0] = 63;
    snap[1] = -64;
    do_start(0, 1'b0, 0);
    for (int k = 0; k < 256; k++) ev($sformatf("s%0d", k), k == 255);
    chk("s_max", gsum(0), 2047);
    chk("s_min", gsum(1), -2048);
    tick();

    // Early termination of lane 5 on the 3rd update
    set_all(1);
    snap[5] = -4;
    do_start(5, 1'b1, 10);
    for (int k = 0; k < 5; k++) ev($sformatf("e%0d", k), k == 4);
    chk("e_l5", gsum(5), -12);
    chk("e_l0", gsum(0), 5);
    chk("e_trig5", ET_L1_TRIGG[5], 1);
    chk("e_allterm", all_terminated, 0);
    tick();

    // Early exit: all lanes terminate on the first event
    set_all(-6);
    do_start(8, 1'b1, 5);
    ev("x0", 1'b0);
    chk("x_trig_all", &ET_L1_TRIGG, 1);
    chk("x_allterm0", all_terminated, 0);
    tick();
    chk("x_allterm1", all_terminated, 1);
    chk("x_rv_wait", result_valid, 0);
    tick();
    chk("x_rv", result_valid, 1);
    chk("x_lanes", n_bad(), 0);
    tick();
    chk("x_rv_drop", result_valid, 0);
    chk("x_busy", busy, 0);
    chk("x_allterm_idle", all_terminated, 0);
    m_active = 1'b0;

    // Restart coincident with a snapshot
    set_all(1);
    do_start(4, 1'b0, 0);
    ev("a0", 1'b0);
    ev("a1", 1'b0);
    set_all(5);
    drive_snap();
    acc_valid = 1'b1;
    start = 1'b1;
    num_acc = NACC_W'(2);
    et_en = 1'b0;
    model_clear();
    tick();
    start = 1'b0;
    acc_valid = 1'b0;
    chk("r_cleared", n_bad(), 0);
    chk("r_busy", busy, 1);
    chk("r_rv", result_valid, 0);
    set_all(1);
    ev("r0", 1'b0);
    ev("r1", 1'b1);
    chk("r_sum", gsum(0), 2);
    tick();

    // Reset mid-run aborts; acc_valid in IDLE is ignored
    set_all(1);
    do_start(4, 1'b0, 0);
    ev("q0", 1'b0);
    ev("q1", 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_clear();
    m_active = 1'b0;
    chk("q_busy", busy, 0);
    chk("q_rv", result_valid, 0);
    chk("q_allterm", all_terminated, 0);
    chk("q_lanes", n_bad(), 0);
    set_all(7);
    ev("q_idle", 1'b0);
    chk("q_idle_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("q_norv%0d", k), result_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
